// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared op encoding, FSM states and constants for the RV32M divider
package div_pkg;

    // funct3[1:0]: bit1 selects remainder, bit0 selects unsigned
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    // Two's-complement negate when neg is set
    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/divider_unsigned.sv
// rtl/divider_unsigned.sv - 32-bit combinational restoring unsigned divider core
//   dividend, divisor : operands
//   quotient, remainder : results (undefined meaning for divisor == 0, caller bypasses)
module divider_unsigned (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [32:0] rem;
    logic [31:0] quo;

    always_comb begin
        rem = '0;
        quo = '0;
        for (int i = 31; i >= 0; i--) begin
            rem = {rem[31:0], dividend[i]};
            if (rem >= {1'b0, divisor}) begin
                rem    = rem - {1'b0, divisor};
                quo[i] = 1'b1;
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem[31:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit, fixed 3-cycle latency
//   clk, rst           : clock, synchronous active-high reset
//   i_valid/o_ready    : request handshake; i_op, i_rs1, i_rs2, i_tag captured at accept
//   i_flush            : kill in-flight operation
//   o_valid/i_ready    : result handshake; o_result, o_tag registered
module div_unit
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [4:0]  i_tag,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic [4:0]  o_tag
);

    div_state_t  state;
    div_op_t     op_q;
    logic [31:0] rs1_q, rs2_q;
    logic [4:0]  tag_q;
    logic [31:0] mag_a, mag_b;
    logic        q_neg, r_neg, div_zero, ovf;

    logic        signed_op, a_neg, b_neg;
    logic [31:0] core_q, core_r;
    logic [31:0] result_next;

    assign signed_op = ~op_q[0];
    assign a_neg     = signed_op & rs1_q[31];
    assign b_neg     = signed_op & rs2_q[31];

    divider_unsigned u_core (
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (core_q),
        .remainder (core_r)
    );

    // Special cases override the core so they share the normal latency
    always_comb begin
        result_next = '0;
        if (div_zero)
            result_next = op_q[1] ? rs1_q : DIV_BY_ZERO_Q;
        else if (ovf)
            result_next = op_q[1] ? 32'd0 : INT_MIN;
        else if (op_q[1])
            result_next = neg_if(r_neg, core_r);
        else
            result_next = neg_if(q_neg, core_q);
    end

    assign o_ready = (state == S_IDLE);
    assign o_valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= OP_DIV;
            rs1_q    <= '0;
            rs2_q    <= '0;
            tag_q    <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            o_result <= '0;
            o_tag    <= '0;
        end else if (i_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        op_q  <= div_op_t'(i_op);
                        rs1_q <= i_rs1;
                        rs2_q <= i_rs2;
                        tag_q <= i_tag;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    mag_a    <= neg_if(a_neg, rs1_q);
                    mag_b    <= neg_if(b_neg, rs2_q);
                    q_neg    <= a_neg ^ b_neg;
                    r_neg    <= a_neg;
                    div_zero <= (rs2_q == 32'd0);
                    ovf      <= signed_op && (rs1_q == INT_MIN) && (rs2_q == 32'hFFFF_FFFF);
                    state    <= S_CALC;
                end
                S_CALC: begin
                    o_result <= result_next;
                    o_tag    <= tag_q;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (i_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [31:0] i_rs1, i_rs2;
    logic [4:0]  i_tag;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [4:0]  o_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_tag    (i_tag),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_tag    (o_tag)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", name, got, exp);
        end
    endtask

    // Called at a negedge with the unit idle; leaves the bench at the negedge
    // where the unit is idle again, so consecutive calls are back-to-back.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
        i_valid = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b; i_tag = tag; i_ready = 1'b1;
        chk({name, " ready"}, {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        i_valid = 1'b0; i_rs1 = ~a; i_rs2 = ~b; i_op = ~op;
        chk({name, " v1"}, {31'd0, o_valid}, 32'd0);
        @(negedge clk);
        chk({name, " v2"}, {31'd0, o_valid}, 32'd0);
        @(negedge clk);
        chk({name, " v3"}, {31'd0, o_valid}, 32'd1);
        chk({name, " result"}, o_result, exp);
        chk({name, " tag"}, {27'd0, o_tag}, {27'd0, tag});
        @(negedge clk);
        chk({name, " idle"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_op = 2'b00; i_rs1 = '0; i_rs2 = '0;
        i_tag = '0; i_flush = 1'b0; i_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst ready",  {31'd0, o_ready}, 32'd1);
        chk("rst valid",  {31'd0, o_valid}, 32'd0);
        chk("rst result", o_result, 32'd0);
        chk("rst tag",    {27'd0, o_tag}, 32'd0);
        rst = 1'b0;

        do_op("div 7/-2",      2'b00, 32'd7,          32'hFFFF_FFFE, 5'd5,  32'hFFFF_FFFD);
        do_op("rem -7%2",      2'b10, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF);
        do_op("remu -7%2",     2'b11, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'h0000_0001);
        do_op("divu x/0",      2'b01, 32'h1234_5678,  32'd0,         5'd8,  32'hFFFF_FFFF);
        do_op("rem x/0",       2'b10, 32'h1234_5678,  32'd0,         5'd9,  32'h1234_5678);
        do_op("div ovf",       2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000);
        do_op("rem ovf",       2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h0000_0000);
        do_op("divu 100/7",    2'b01, 32'd100,        32'd7,         5'd12, 32'd14);
        do_op("remu 100/7",    2'b11, 32'd100,        32'd7,         5'd13, 32'd2);
        do_op("div -100/7",    2'b00, 32'hFFFF_FF9C,  32'd7,         5'd14, 32'hFFFF_FFF2);
        do_op("rem -100/7",    2'b10, 32'hFFFF_FF9C,  32'd7,         5'd15, 32'hFFFF_FFFE);
        do_op("div -1/0",      2'b00, 32'hFFFF_FFFF,  32'd0,         5'd16, 32'hFFFF_FFFF);
        do_op("remu neg/0",    2'b11, 32'hFFFF_FF9C,  32'd0,         5'd17, 32'hFFFF_FF9C);
        do_op("divu max/1",    2'b01, 32'hFFFF_FFFF,  32'd1,         5'd31, 32'hFFFF_FFFF);

        // Backpressure: hold result for 5 cycles with i_ready low
        i_valid = 1'b1; i_op = 2'b00; i_rs1 = 32'hFFFF_FF9C; i_rs2 = 32'hFFFF_FFF9;
        i_tag = 5'd21; i_ready = 1'b0;
        @(negedge clk);
        i_valid = 1'b0; i_rs1 = '0; i_rs2 = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("hold valid",  {31'd0, o_valid}, 32'd1);
            chk("hold result", o_result, 32'd14);
            chk("hold tag",    {27'd0, o_tag}, 32'd21);
            chk("hold ready",  {31'd0, o_ready}, 32'd0);
            @(negedge clk);
        end
        i_ready = 1'b1;
        @(negedge clk);
        chk("release ready", {31'd0, o_ready}, 32'd1);
        chk("release valid", {31'd0, o_valid}, 32'd0);
        do_op("b2b divu", 2'b01, 32'd1000, 32'd10, 5'd3, 32'd100);

        // Flush while in CALC
        i_valid = 1'b1; i_op = 2'b00; i_rs1 = 32'd50; i_rs2 = 32'd5; i_tag = 5'd1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("flush ready", {31'd0, o_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("flush no valid", {31'd0, o_valid}, 32'd0);
            @(negedge clk);
        end
        do_op("after flush", 2'b10, 32'd50, 32'd7, 5'd2, 32'd1);

        // Reset while in PREP
        i_valid = 1'b1; i_op = 2'b01; i_rs1 = 32'd9; i_rs2 = 32'd3; i_tag = 5'd4;
        @(negedge clk);
        i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst ready",  {31'd0, o_ready}, 32'd1);
        chk("mid rst result", o_result, 32'd0);
        chk("mid rst tag",    {27'd0, o_tag}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("mid rst no valid", {31'd0, o_valid}, 32'd0);
            @(negedge clk);
        end
        do_op("after rst", 2'b00, 32'hFFFF_FFF7, 32'd3, 5'd30, 32'hFFFF_FFFD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
